// File: rtl/ibp_assoc.sv
`default_nettype none
// ============================================================================
// Module   : ibp_assoc
// Brief    : Set-associative indirect branch target predictor with
//            path-history index hashing, saturating confidence counters,
//            per-set round-robin replacement and a registered prediction port.
//            A sweep FSM clears the array one set per cycle after reset/flush.
// Revision : 1.0 - initial release
// ============================================================================
module ibp_assoc #(
  parameter int SETS      = 128,
  parameter int WAYS      = 4,
  parameter int TAG_BITS  = 16,
  parameter int CONF_BITS = 2,
  localparam int IDX      = $clog2(SETS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  output logic           busy_o,
  input  logic           lookup_valid_i,
  input  logic [63:0]    lookup_pc_i,
  output logic           pred_valid_o,
  output logic           pred_hit_o,
  output logic [63:0]    pred_target_o,
  output logic [IDX-1:0] pred_hist_o,
  input  logic           update_valid_i,
  input  logic [63:0]    update_pc_i,
  input  logic [IDX-1:0] update_hist_i,
  input  logic [63:0]    update_target_i
);

  localparam int c_way_bits = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CONF_BITS-1:0] c_conf_max = '1;
  localparam logic [CONF_BITS-1:0] c_conf_one = CONF_BITS'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [IDX-1:0] r_cnt, w_cnt_nxt;
  logic [IDX-1:0] r_hist, w_hist_nxt;

  // Predictor storage; valid/conf/rr are brought to a known state by the sweep.
  logic                  r_valid  [SETS][WAYS];
  logic [TAG_BITS-1:0]   r_tag    [SETS][WAYS];
  logic [63:0]           r_target [SETS][WAYS];
  logic [CONF_BITS-1:0]  r_conf   [SETS][WAYS];
  logic [c_way_bits-1:0] r_rr     [SETS];

  logic                  w_busy;
  logic                  w_up_accept;
  logic [IDX-1:0]        w_lk_idx, w_up_idx;
  logic [TAG_BITS-1:0]   w_lk_tag, w_up_tag;
  logic                  w_lk_hit;
  logic [63:0]           w_lk_target;
  logic                  w_up_hit, w_inv_found;
  logic [c_way_bits-1:0] w_up_way, w_inv_way, w_victim;
  logic                  w_unused_pc_bits;

  assign w_busy      = (r_state != ST_IDLE);
  assign busy_o      = w_busy;
  // A flush in the same cycle takes priority over an update.
  assign w_up_accept = update_valid_i && !w_busy && !flush_i;

  assign w_lk_idx = lookup_pc_i[IDX+1:2] ^ r_hist;
  assign w_lk_tag = lookup_pc_i[IDX+2 +: TAG_BITS];
  assign w_up_idx = update_pc_i[IDX+1:2] ^ update_hist_i;
  assign w_up_tag = update_pc_i[IDX+2 +: TAG_BITS];

  assign w_unused_pc_bits = ^{lookup_pc_i[63:IDX+2+TAG_BITS], lookup_pc_i[1:0],
                              update_pc_i[63:IDX+2+TAG_BITS], update_pc_i[1:0]};

  // Lookup hit search; scanning downwards leaves the lowest matching way.
  always_comb begin
    w_lk_hit    = 1'b0;
    w_lk_target = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag) &&
          (r_conf[w_lk_idx][w] != '0)) begin
        w_lk_hit    = 1'b1;
        w_lk_target = r_target[w_lk_idx][w];
      end
    end
  end

  // Update tag match and victim selection (lowest invalid way, else rr).
  always_comb begin
    w_up_hit    = 1'b0;
    w_up_way    = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = c_way_bits'(w);
      end
      if (!r_valid[w_up_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = c_way_bits'(w);
      end
    end
    w_victim = w_inv_found ? w_inv_way : r_rr[w_up_idx];
  end

  // Sweep FSM next state, sweep counter and global path history.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hist_nxt  = r_hist;
    case (r_state)
      ST_INIT, ST_FLUSH: begin
        if (flush_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == IDX'(SETS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
    if (flush_i) begin
      w_hist_nxt = '0;
    end else if (w_up_accept) begin
      w_hist_nxt = {r_hist[IDX-2:0], 1'b0} ^ update_target_i[IDX+1:2];
    end
  end

  // FSM, counter and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_hist  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hist  <= w_hist_nxt;
    end
  end

  // Array write port: sweep clearing has priority over branch updates.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[r_cnt][w] <= 1'b0;
        r_conf[r_cnt][w]  <= '0;
      end
      r_rr[r_cnt] <= '0;
    end else if (w_up_accept) begin
      if (w_up_hit) begin
        if (r_target[w_up_idx][w_up_way] == update_target_i) begin
          if (r_conf[w_up_idx][w_up_way] != c_conf_max)
            r_conf[w_up_idx][w_up_way] <= r_conf[w_up_idx][w_up_way] + 1'b1;
        end else if (r_conf[w_up_idx][w_up_way] != '0) begin
          r_conf[w_up_idx][w_up_way] <= r_conf[w_up_idx][w_up_way] - 1'b1;
        end else begin
          r_target[w_up_idx][w_up_way] <= update_target_i;
          r_conf[w_up_idx][w_up_way]   <= c_conf_one;
        end
      end else begin
        r_valid[w_up_idx][w_victim]  <= 1'b1;
        r_tag[w_up_idx][w_victim]    <= w_up_tag;
        r_target[w_up_idx][w_victim] <= update_target_i;
        r_conf[w_up_idx][w_victim]   <= c_conf_one;
        if (!w_inv_found)
          r_rr[w_up_idx] <= (r_rr[w_up_idx] == c_way_bits'(WAYS - 1)) ? '0
                                                                       : r_rr[w_up_idx] + 1'b1;
      end
    end
  end

  // Registered prediction port; no hits are reported while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_o  <= 1'b0;
      pred_hit_o    <= 1'b0;
      pred_target_o <= '0;
      pred_hist_o   <= '0;
    end else begin
      pred_valid_o  <= lookup_valid_i;
      pred_hit_o    <= lookup_valid_i && !w_busy && w_lk_hit;
      pred_target_o <= (lookup_valid_i && !w_busy && w_lk_hit) ? w_lk_target : '0;
      pred_hist_o   <= r_hist;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibp_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibp_assoc
// Brief    : Scoreboard bench for ibp_assoc with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibp_assoc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        lookup_valid_i = 1'b0;
  logic [63:0] lookup_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_hit_o;
  logic [63:0] pred_target_o;
  logic [6:0]  pred_hist_o;
  logic        update_valid_i = 1'b0;
  logic [63:0] update_pc_i = '0;
  logic [6:0]  update_hist_i = '0;
  logic [63:0] update_target_i = '0;

  ibp_assoc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .busy_o          (busy_o),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_pc_i     (lookup_pc_i),
    .pred_valid_o    (pred_valid_o),
    .pred_hit_o      (pred_hit_o),
    .pred_target_o   (pred_target_o),
    .pred_hist_o     (pred_hist_o),
    .update_valid_i  (update_valid_i),
    .update_pc_i     (update_pc_i),
    .update_hist_i   (update_hist_i),
    .update_target_i (update_target_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        hit;
    logic [63:0] tgt;
    logic [6:0]  hist;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_lk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare any prediction against the scoreboard.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("lk%0d_valid", e.id), {63'd0, pred_valid_o}, 64'd1);
      chk($sformatf("lk%0d_hit", e.id), {63'd0, pred_hit_o}, {63'd0, e.hit});
      chk($sformatf("lk%0d_target", e.id), pred_target_o, e.tgt);
      chk($sformatf("lk%0d_hist", e.id), {57'd0, pred_hist_o}, {57'd0, e.hist});
    end else if (pred_valid_o) begin
      chk("spurious_valid", {63'd0, pred_valid_o}, 64'd0);
    end
  endtask

  task automatic push_lookup(input logic [63:0] pc, input logic hit,
                             input logic [63:0] tgt, input logic [6:0] hist);
    exp_t e;
    n_lk++;
    e.id = n_lk; e.hit = hit; e.tgt = tgt; e.hist = hist;
    lookup_valid_i = 1'b1;
    lookup_pc_i    = pc;
    sb.push_back(e);
  endtask

  task automatic set_update(input logic [63:0] pc, input logic [6:0] hist, input logic [63:0] tgt);
    update_valid_i  = 1'b1;
    update_pc_i     = pc;
    update_hist_i   = hist;
    update_target_i = tgt;
  endtask

  task automatic idle_inputs();
    lookup_valid_i = 1'b0;
    update_valid_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic lookup(input logic [63:0] pc, input logic hit,
                        input logic [63:0] tgt, input logic [6:0] hist);
    push_lookup(pc, hit, tgt, hist);
    cyc();
    idle_inputs();
  endtask

  task automatic update(input logic [63:0] pc, input logic [6:0] hist, input logic [63:0] tgt);
    set_update(pc, hist, tgt);
    cyc();
    idle_inputs();
  endtask

  // Count cycles until busy_o drops, bounded.
  task automatic busy_len(input string tag, input int exp_len);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (busy_o && n < 400);
    chk(tag, 64'(n), 64'(exp_len));
  endtask

  initial begin
    int c;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd1);
    chk("rst_pvalid", {63'd0, pred_valid_o}, 64'd0);
    chk("rst_phit", {63'd0, pred_hit_o}, 64'd0);
    chk("rst_ptarget", pred_target_o, 64'd0);
    chk("rst_phist", {57'd0, pred_hist_o}, 64'd0);
    rst_n = 1'b1;
    busy_len("init_len", 128);

    // Cold miss, then allocate
    lookup(64'h1000, 1'b0, 64'h0, 7'd0);
    update(64'h1000, 7'd0, 64'h2000);
    lookup(64'h1000, 1'b1, 64'h2000, 7'd0);

    // Hysteresis and saturation
    update(64'h1000, 7'd0, 64'h3000);
    lookup(64'h1000, 1'b0, 64'h0, 7'd0);
    update(64'h1000, 7'd0, 64'h3000);
    lookup(64'h1000, 1'b1, 64'h3000, 7'd0);
    repeat (3) update(64'h1000, 7'd0, 64'h3000);
    lookup(64'h1000, 1'b1, 64'h3000, 7'd0);
    repeat (2) update(64'h1000, 7'd0, 64'h5000);
    lookup(64'h1000, 1'b1, 64'h3000, 7'd0);
    update(64'h1000, 7'd0, 64'h5000);
    lookup(64'h1000, 1'b0, 64'h0, 7'd0);
    update(64'h1000, 7'd0, 64'h5000);
    lookup(64'h1000, 1'b1, 64'h5000, 7'd0);

    // Eviction in set 0
    update(64'h1000, 7'd0, 64'h5000);
    for (int k = 1; k <= 3; k++) update(64'h1000 + 64'(k) * 64'h200, 7'd0, 64'h8000 + 64'(k) * 64'h200);
    lookup(64'h1000, 1'b1, 64'h5000, 7'd0);
    for (int k = 1; k <= 3; k++) lookup(64'h1000 + 64'(k) * 64'h200, 1'b1, 64'h8000 + 64'(k) * 64'h200, 7'd0);
    update(64'h1800, 7'd0, 64'h8800);
    lookup(64'h1000, 1'b0, 64'h0, 7'd0);
    for (int k = 1; k <= 4; k++) lookup(64'h1000 + 64'(k) * 64'h200, 1'b1, 64'h8000 + 64'(k) * 64'h200, 7'd0);
    update(64'h1A00, 7'd0, 64'h8A00);
    lookup(64'h1200, 1'b0, 64'h0, 7'd0);
    lookup(64'h1A00, 1'b1, 64'h8A00, 7'd0);
    lookup(64'h1400, 1'b1, 64'h8400, 7'd0);

    // Same-cycle lookup and update: read-before-write
    push_lookup(64'h1008, 1'b0, 64'h0, 7'd0);
    set_update(64'h1008, 7'd0, 64'h2600);
    cyc(); idle_inputs();
    lookup(64'h1008, 1'b1, 64'h2600, 7'd0);
    update(64'h1004, 7'd0, 64'h2200);
    update(64'h1004, 7'd0, 64'h2400);
    lookup(64'h1004, 1'b0, 64'h0, 7'd0);
    push_lookup(64'h1004, 1'b0, 64'h0, 7'd0);
    set_update(64'h1004, 7'd0, 64'h2400);
    cyc(); idle_inputs();
    lookup(64'h1004, 1'b1, 64'h2400, 7'd0);
    push_lookup(64'h1004, 1'b1, 64'h2400, 7'd0);
    set_update(64'h1004, 7'd0, 64'h2600);
    cyc(); idle_inputs();
    lookup(64'h1004, 1'b0, 64'h0, 7'd0);

    // History: same-cycle update sets hist to 1; lookups then hash with it
    push_lookup(64'h1008, 1'b1, 64'h2600, 7'd0);
    set_update(64'h100C, 7'd0, 64'h4);
    cyc(); idle_inputs();
    lookup(64'h1008, 1'b1, 64'h4, 7'd1);
    lookup(64'h100C, 1'b1, 64'h2600, 7'd1);

    // Flush colliding with an update, second flush at sweep cycle 50
    flush_i = 1'b1;
    set_update(64'h1010, 7'd1, 64'h8);
    cyc(); idle_inputs();
    chk("flush_busy", {63'd0, busy_o}, 64'd1);
    c = 0;
    while (c < 400) begin
      c++;
      if (c == 10) push_lookup(64'h1008, 1'b0, 64'h0, 7'd0);
      if (c == 20) set_update(64'h1014, 7'd0, 64'h4);
      if (c == 50) flush_i = 1'b1;
      if (c == 60) set_update(64'h1018, 7'd0, 64'h4);
      cyc(); idle_inputs();
      if (!busy_o) break;
    end
    chk("flush_len", 64'(c), 64'd178);
    lookup(64'h1008, 1'b0, 64'h0, 7'd0);
    lookup(64'h100C, 1'b0, 64'h0, 7'd0);
    lookup(64'h1400, 1'b0, 64'h0, 7'd0);
    lookup(64'h1010, 1'b0, 64'h0, 7'd0);
    lookup(64'h1018, 1'b0, 64'h0, 7'd0);

    // Reset pulsed mid-sweep
    update(64'h1004, 7'd0, 64'h2200);
    lookup(64'h1004, 1'b1, 64'h2200, 7'd0);
    flush_i = 1'b1;
    cyc(); idle_inputs();
    for (int i = 1; i < 20; i++) cyc();
    push_lookup(64'h1004, 1'b0, 64'h0, 7'd0);
    cyc(); idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pvalid", {63'd0, pred_valid_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd1);
    cyc(); cyc();
    rst_n = 1'b1;
    busy_len("rst_len", 128);
    lookup(64'h1004, 1'b0, 64'h0, 7'd0);

    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
